// File: rtl/bist_controller.sv
// Built-in self-test sequencer: drives LFSR vectors into a circuit under test, compacts its
// responses in a MISR and compares the final signature against a golden value.
module bist_controller #(
  parameter int unsigned         PAT_W     = 16,
  parameter int unsigned         RSP_W     = 16,
  parameter int unsigned         N_PAT     = 1000,
  parameter int unsigned         RSP_LAT   = 1,
  parameter logic [PAT_W-1:0]    LFSR_SEED = 16'h0001,
  parameter logic [PAT_W-1:0]    LFSR_TAPS = 16'hB400,
  parameter logic [RSP_W-1:0]    MISR_TAPS = 16'hB400,
  parameter logic [RSP_W-1:0]    GOLDEN    = 16'h0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             test_mode,
  output logic [PAT_W-1:0] test_vector,
  input  logic [RSP_W-1:0] cut_response,
  output logic             busy,
  output logic             bist_end,
  output logic             pass_nfail,
  output logic [RSP_W-1:0] signature
);

  localparam int unsigned     CntW      = $clog2(N_PAT + 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(N_PAT - 1);
  localparam logic [2:0]      FlushLast = (RSP_LAT > 0) ? 3'(RSP_LAT - 1) : 3'd0;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StCompare} state_e;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  lfsr_q, lfsr_d;
  logic [RSP_W-1:0]  misr_q, misr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        flush_q, flush_d;
  logic              pass_q, pass_d;
  logic              end_q, end_d;
  logic              vec_valid;
  logic              cap_en;

  assign vec_valid = (state_q == StRun);

  // Capture enable follows the vector-valid flag through the same latency as the CUT.
  generate
    if (RSP_LAT == 0) begin : g_no_lat
      assign cap_en = vec_valid;
    end else begin : g_lat
      logic [RSP_LAT-1:0] valid_pipe_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          valid_pipe_q <= '0;
        end else begin
          valid_pipe_q <= RSP_LAT'({valid_pipe_q, vec_valid});
        end
      end
      assign cap_en = valid_pipe_q[RSP_LAT-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      pass_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      pass_q  <= pass_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    pass_d  = pass_q;
    end_d   = 1'b0;

    if (cap_en) begin
      misr_d = {misr_q[RSP_W-2:0], ^(misr_q & MISR_TAPS)} ^ cut_response;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          cnt_d   = '0;
          flush_d = '0;
          pass_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        lfsr_d = {lfsr_q[PAT_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = (RSP_LAT > 0) ? StFlush : StCompare;
        end
      end
      StFlush: begin
        flush_d = flush_q + 3'd1;
        if (flush_q == FlushLast) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        pass_d  = (misr_q == GOLDEN);
        end_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign test_mode   = (state_q == StRun) || (state_q == StFlush);
  assign busy        = (state_q != StIdle);
  assign test_vector = vec_valid ? lfsr_q : '0;
  assign signature   = misr_q;
  assign pass_nfail  = pass_q;
  assign bist_end    = end_q;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench: two controller instances (zero and two-cycle CUT latency) checked
// cycle by cycle against a sequence-level model of vectors and signatures.
module tb_bist_controller;

  localparam int         N    = 4;
  localparam logic [3:0] SEED = 4'h1;
  localparam logic [3:0] TAPS = 4'hC;
  localparam logic [3:0] GOLD = 4'h0;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start0, start1;
  logic       tm0, tm1, bz0, bz1, be0, be1, pf0, pf1;
  logic [3:0] tv0, tv1, sg0, sg1, cut0, cut1;
  logic [3:0] orm0, orm1, xm0, xm1;
  logic [3:0] d1, d2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_vec [N];
  logic [3:0] exp_sig [N+1];

  always #5 clock = ~clock;

  // CUT models: identity with optional stuck-at (OR) and inversion (XOR) faults.
  assign cut0 = (tv0 | orm0) ^ xm0;
  always @(posedge clock) begin
    d1 <= (tv1 | orm1) ^ xm1;
    d2 <= d1;
  end
  assign cut1 = d2;

  bist_controller #(
    .PAT_W(4), .RSP_W(4), .N_PAT(N), .RSP_LAT(0),
    .LFSR_SEED(SEED), .LFSR_TAPS(TAPS), .MISR_TAPS(TAPS), .GOLDEN(GOLD)
  ) u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .test_mode(tm0), .test_vector(tv0),
    .cut_response(cut0), .busy(bz0), .bist_end(be0), .pass_nfail(pf0), .signature(sg0)
  );

  bist_controller #(
    .PAT_W(4), .RSP_W(4), .N_PAT(N), .RSP_LAT(2),
    .LFSR_SEED(SEED), .LFSR_TAPS(TAPS), .MISR_TAPS(TAPS), .GOLDEN(GOLD)
  ) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .test_mode(tm1), .test_vector(tv1),
    .cut_response(cut1), .busy(bz1), .bist_end(be1), .pass_nfail(pf1), .signature(sg1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Vector list from the LFSR rule, then the running MISR signature after each capture.
  task automatic build_model(input logic [3:0] orm, input logic [3:0] xm);
    logic [3:0] v, r;
    v = SEED;
    for (int k = 0; k < N; k++) begin
      exp_vec[k] = v;
      v = {v[2:0], ^(v & TAPS)};
    end
    exp_sig[0] = 4'h0;
    for (int k = 0; k < N; k++) begin
      r = (exp_vec[k] | orm) ^ xm;
      exp_sig[k+1] = {exp_sig[k][2:0], ^(exp_sig[k] & TAPS)} ^ r;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " tm0"}, 32'(tm0), 0);
    chk({tag, " tv0"}, 32'(tv0), 0);
    chk({tag, " bz0"}, 32'(bz0), 0);
    chk({tag, " be0"}, 32'(be0), 0);
    chk({tag, " pf0"}, 32'(pf0), 0);
    chk({tag, " sg0"}, 32'(sg0), 0);
    chk({tag, " tm1"}, 32'(tm1), 0);
    chk({tag, " bz1"}, 32'(bz1), 0);
    chk({tag, " sg1"}, 32'(sg1), 0);
  endtask

  // Pulses start in the current cycle and checks every cycle up to and including bist_end.
  // busy_pulse re-asserts start in that cycle; chain leaves the run in its bist_end cycle.
  task automatic do_run(input string name, input bit sel, input int busy_pulse, input bit chain);
    int         lat;
    int         last;
    int         cap;
    logic [3:0] orm, xm;
    lat  = sel ? 2 : 0;
    last = N + lat + 2;
    orm  = sel ? orm1 : orm0;
    xm   = sel ? xm1 : xm0;
    build_model(orm, xm);
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    for (int c = 1; c <= last; c++) begin
      cap = c - 1 - lat;
      if (cap < 0) cap = 0;
      if (cap > N) cap = N;
      chk($sformatf("%s busy c%0d", name, c), 32'(sel ? bz1 : bz0), 32'(c <= N + lat + 1));
      chk($sformatf("%s test_mode c%0d", name, c), 32'(sel ? tm1 : tm0), 32'(c <= N + lat));
      chk($sformatf("%s vector c%0d", name, c), 32'(sel ? tv1 : tv0),
          (c <= N) ? 32'(exp_vec[c-1]) : 32'd0);
      chk($sformatf("%s bist_end c%0d", name, c), 32'(sel ? be1 : be0), 32'(c == last));
      chk($sformatf("%s signature c%0d", name, c), 32'(sel ? sg1 : sg0), 32'(exp_sig[cap]));
      chk($sformatf("%s pass_nfail c%0d", name, c), 32'(sel ? pf1 : pf0),
          (c < last) ? 32'd0 : 32'(exp_sig[N] == GOLD));
      if (c == busy_pulse) set_start(sel, 1'b1);
      if (c < last) begin
        tick();
        set_start(sel, 1'b0);
      end
    end
    if (!chain) begin
      tick();
      chk({name, " bist_end after"}, 32'(sel ? be1 : be0), 0);
      chk({name, " busy after"}, 32'(sel ? bz1 : bz0), 0);
      chk({name, " pass held"}, 32'(sel ? pf1 : pf0), 32'(exp_sig[N] == GOLD));
      chk({name, " signature held"}, 32'(sel ? sg1 : sg0), 32'(exp_sig[N]));
    end
  endtask

  initial begin
    start0 = 1'b0;
    start1 = 1'b0;
    orm0 = 4'h0; xm0 = 4'h0;
    orm1 = 4'h0; xm1 = 4'h0;

    #12;
    chk_reset_vals("in reset");
    reset = 1'b1;
    tick();
    chk_reset_vals("after release");

    do_run("identity", 1'b0, -1, 1'b0);
    orm0 = 4'h1;
    do_run("stuck_at", 1'b0, -1, 1'b0);
    orm0 = 4'h0;
    do_run("latency", 1'b1, -1, 1'b0);

    do_run("busy_start", 1'b0, 2, 1'b1);
    do_run("chained", 1'b0, -1, 1'b0);

    // Reset asserted in cycle 3 of a run, between clock edges.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_reset_vals("mid-run reset");
    #2;
    reset = 1'b1;
    tick();
    do_run("after reset", 1'b0, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        orm0 = 4'h0; xm0 = 4'h0; orm1 = 4'h0; xm1 = 4'h0;
      end else begin
        orm0 = 4'($urandom_range(0, 15));
        xm0  = 4'($urandom_range(0, 15));
        orm1 = 4'($urandom_range(0, 15));
        xm1  = 4'($urandom_range(0, 15));
      end
      do_run($sformatf("rand%0d", i), i[0], -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
# bist_controller

Runs one self-test of a circuit under test (CUT) and reports the result. It accepts the single-cycle start pulse from the top-level `bist_start` edge detector, drives LFSR pseudo-random vectors into the CUT for a fixed pattern count, and compacts the CUT responses in a MISR. It then compares the final signature against a golden value and returns `bist_end` / `pass_nfail` to the top level.

## Interface
- `PAT_W`, 16: LFSR and test-vector width.
- `RSP_W`, 16: CUT response and MISR width.
- `N_PAT`, 1000: patterns applied per run; must be ≥1.
- `RSP_LAT`, 1: CUT latency in cycles; range 0..7.
- `LFSR_SEED`, 16'h0001: LFSR load value; must be nonzero.
- `LFSR_TAPS`, 16'hB400: LFSR feedback mask.
- `MISR_TAPS`, 16'hB400: MISR feedback mask.
- `GOLDEN`, 16'h0000: expected final signature.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: single-cycle start pulse.
- `test_mode` out 1: selects BIST vectors at the CUT inputs.
- `test_vector` out PAT_W: vector to the CUT.
- `cut_response` in RSP_W: CUT output.
- `busy` out 1: run in progress.
- `bist_end` out 1: one-cycle completion pulse.
- `pass_nfail` out 1: result; 1 means pass.
- `signature` out RSP_W: current MISR contents.

## Operation
- FSM states: IDLE, RUN, FLUSH, COMPARE.
- **IDLE**
  - When `start`=1: load LFSR with `LFSR_SEED`, clear MISR and the pattern counter, clear `pass_nfail`, go to RUN.
  - Otherwise stay in IDLE.
- **RUN**
  - `test_vector` = LFSR.
  - Each cycle: LFSR <= {LFSR[PAT_W-2:0], ^(LFSR & LFSR_TAPS)}, and the counter increments.
  - After `N_PAT` vectors: go to FLUSH if `RSP_LAT`>0, else go to COMPARE.
- **FLUSH**
  - Lasts `RSP_LAT` cycles.
  - `test_vector` = 0; the MISR keeps capturing in-flight responses.
  - Then go to COMPARE.
- **COMPARE**
  - One cycle.
  - Register `pass_nfail` <= (MISR == `GOLDEN`) and `bist_end` <= 1.
  - Go to IDLE.
- **Capture enable**
  - The "vector valid" flag (high in RUN) delayed by `RSP_LAT` stages; combinational when `RSP_LAT`=0.
  - Exactly `N_PAT` captures per run.
  - On capture: MISR <= {MISR[RSP_W-2:0], ^(MISR & MISR_TAPS)} ^ `cut_response`.
- **Counter width**: $clog2(N_PAT+1).
- **Outputs**
  - `test_mode` = (state is RUN or FLUSH).
  - `busy` = (state ≠ IDLE).
  - `test_vector` = 0 outside RUN.
  - `signature` = MISR at all times; it holds after the run.
- **Boundary conditions**
  - `start` while `busy`: ignored, with no effect on the run.
  - `start` during the `bist_end` cycle: accepted (state is IDLE).
  - `pass_nfail` holds until the next accepted `start` or reset.
  - `reset` low at any time, including mid-run: all state returns to reset values immediately; `test_mode` drops asynchronously.
- **Reset values**: state IDLE, `test_mode` 0, `test_vector` 0, `busy` 0, `bist_end` 0, `pass_nfail` 0, `signature` 0, LFSR = `LFSR_SEED`.

## Timing
- `start` is sampled high at the edge ending cycle 0.
- Vector k (k = 0..`N_PAT`-1) is driven during cycle 1+k.
- The response to vector k is captured at the edge ending cycle 1+k+`RSP_LAT`.
- COMPARE occupies cycle `N_PAT`+`RSP_LAT`+1.
- `bist_end`=1 for exactly cycle `N_PAT`+`RSP_LAT`+2, with `pass_nfail` valid from that same cycle.
- `busy` is high in cycles 1 through `N_PAT`+`RSP_LAT`+1.
- Throughput: a new run may start in the `bist_end` cycle.

## Test plan
Common settings: PAT_W=RSP_W=4, LFSR_SEED=4'h1, LFSR_TAPS=MISR_TAPS=4'hC, N_PAT=4.

- **Identity CUT, pass**: RSP_LAT=0, GOLDEN=4'h0.
  - Pulse `start` -> vectors 1,2,4,9 in cycles 1-4.
  - `signature`=4'h0; `bist_end` in cycle 6; `pass_nfail`=1.
- **Stuck-at fault**: same setup, response bit0 stuck-at-1.
  - Responses 1,3,5,9 -> `signature`=4'h6; `pass_nfail`=0; `bist_end` in cycle 6.
- **Latency**: RSP_LAT=2, CUT = 2-register delay of the vector.
  - `signature`=4'h0; FLUSH lasts 2 cycles; `bist_end` in cycle 8; `test_mode` high in cycles 1-6.
- **Start while busy**: second `start` pulse in cycle 2.
  - Run is unaffected; exactly one `bist_end`; `start` in the `bist_end` cycle launches a new run, with `pass_nfail` cleared the next cycle.
- **Reset mid-run**: `reset` low in cycle 3.
  - All outputs go to reset values immediately.
  - A later `start` reproduces the scenario 1 result exactly.
